// File: rtl/spi_pkg.sv
// Shared types and default sizing for the SPI master controller.
package spi_pkg;

    localparam int DEF_WIDTH   = 10;
    localparam int DEF_CLK_DIV = 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_HOLD,
        S_DONE
    } spi_state_t;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period timer: reloading down-counter that emits a one-cycle tick every CLK_DIV enabled cycles.
module spi_clk_div #(
    parameter int CLK_DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int            CW   = $clog2(CLK_DIV + 1);
    localparam logic [CW-1:0] LOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= LOAD;
        end else if (en) begin
            cnt <= (cnt == '0) ? LOAD : cnt - CW'(1);
        end
    end

    assign tick = en && !clr && (cnt == '0);

endmodule

// File: rtl/spi_master_ctrl.sv
// SPI mode-0 master: one WIDTH-bit full-duplex transfer per accepted start, MSB first.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   S_IDLE  | cs_n high, waiting for start; captures tx_data on accept
//   S_SETUP | cs_n low, first mosi bit settling for one half-period
//   S_SHIFT | sclk toggling; sample miso on rise, advance mosi on fall
//   S_HOLD  | cs_n low, sclk low for one half-period after last fall
//   S_DONE  | one-cycle done pulse, cs_n high, rx_data just updated
module spi_master_ctrl
    import spi_pkg::*;
#(
    parameter int WIDTH   = DEF_WIDTH,
    parameter int CLK_DIV = DEF_CLK_DIV
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] tx_data,
    input  logic             miso,
    output logic             sclk,
    output logic             mosi,
    output logic             cs_n,
    output logic [WIDTH-1:0] rx_data,
    output logic             busy,
    output logic             done
);

    localparam int            BW       = $clog2(WIDTH + 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(WIDTH);

    spi_state_t       state, state_nxt;
    logic             tick, div_en, div_clr;
    logic             sclk_q;
    logic [WIDTH-1:0] tx_sr, rx_sr;
    logic [BW-1:0]    bit_cnt;
    logic             last_fall;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk  (clk),
        .rst  (rst),
        .en   (div_en),
        .clr  (div_clr),
        .tick (tick)
    );

    assign last_fall = (state == S_SHIFT) && tick && sclk_q && (bit_cnt == LAST_BIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        div_en    = 1'b0;
        div_clr   = 1'b0;
        case (state)
            S_IDLE: begin
                div_clr = 1'b1;
                if (start) state_nxt = S_SETUP;
            end
            S_SETUP: begin
                div_en = 1'b1;
                if (tick) state_nxt = S_SHIFT;
            end
            S_SHIFT: begin
                div_en = 1'b1;
                if (last_fall) state_nxt = S_HOLD;
            end
            S_HOLD: begin
                div_en = 1'b1;
                if (tick) state_nxt = S_DONE;
            end
            S_DONE: begin
                div_clr   = 1'b1;
                state_nxt = S_IDLE;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Every SHIFT tick toggles sclk; the last fall leaves it low for HOLD.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_sr   <= '0;
            rx_sr   <= '0;
            bit_cnt <= '0;
            sclk_q  <= 1'b0;
            rx_data <= '0;
        end else begin
            if (state == S_IDLE && start) begin
                tx_sr   <= tx_data;
                bit_cnt <= '0;
                sclk_q  <= 1'b0;
            end
            if (state == S_SHIFT && tick) begin
                sclk_q <= ~sclk_q;
                if (!sclk_q) begin
                    rx_sr   <= {rx_sr[WIDTH-2:0], miso};
                    bit_cnt <= bit_cnt + BW'(1);
                end else if (bit_cnt != LAST_BIT) begin
                    tx_sr <= {tx_sr[WIDTH-2:0], 1'b0};
                end
            end
            // Loaded on the edge into DONE so the new word is visible during the done pulse.
            if (state == S_HOLD && tick) begin
                rx_data <= rx_sr;
            end
        end
    end

    assign sclk = sclk_q;
    assign mosi = tx_sr[WIDTH-1];
    assign cs_n = (state == S_IDLE) || (state == S_DONE);
    assign busy = (state != S_IDLE);
    assign done = (state == S_DONE);

endmodule

// File: tb/tb_spi_master_ctrl.sv
// Directed bench for spi_master_ctrl: a 10-bit/div-2 instance with a slave model and a 2-bit/div-1 instance.
module tb_spi_master_ctrl;

    typedef struct {
        logic [9:0] tx;
        logic [9:0] slave;
        bit         loop;
        logic [9:0] exp_rx;
    } vec_t;

    int n_cmp = 0;
    int n_bad = 0;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst_big, start_big, miso_big, sclk_big, mosi_big, cs_n_big, busy_big, done_big;
    logic [9:0] tx_big, rx_big;
    logic       rst_sml, start_sml, miso_sml, sclk_sml, mosi_sml, cs_n_sml, busy_sml, done_sml;
    logic [1:0] tx_sml, rx_sml;

    spi_master_ctrl #(.WIDTH(10), .CLK_DIV(2)) u_big (
        .clk(clk), .rst(rst_big), .start(start_big), .tx_data(tx_big), .miso(miso_big),
        .sclk(sclk_big), .mosi(mosi_big), .cs_n(cs_n_big), .rx_data(rx_big),
        .busy(busy_big), .done(done_big)
    );

    spi_master_ctrl #(.WIDTH(2), .CLK_DIV(1)) u_sml (
        .clk(clk), .rst(rst_sml), .start(start_sml), .tx_data(tx_sml), .miso(miso_sml),
        .sclk(sclk_sml), .mosi(mosi_sml), .cs_n(cs_n_sml), .rx_data(rx_sml),
        .busy(busy_sml), .done(done_sml)
    );

    // Slave model for the wide instance: presents slave_word MSB first, advancing after each sclk fall.
    logic [9:0] slave_word = '0;
    logic [9:0] tx_cur = '0;
    bit         big_loop = 1'b1;
    int         rises = 0, falls = 0, mosi_bad = 0;
    logic       prev_sclk = 1'b0;

    assign miso_big = big_loop ? mosi_big : ((falls < 10) ? slave_word[9 - falls] : 1'b0);

    always @(negedge clk) begin
        if (!busy_big) begin
            rises    = 0;
            falls    = 0;
            mosi_bad = 0;
        end else begin
            if (sclk_big && !prev_sclk) begin
                if (rises < 10 && mosi_big !== tx_cur[9 - rises]) mosi_bad++;
                rises++;
            end
            if (!sclk_big && prev_sclk) falls++;
        end
        prev_sclk = sclk_big;
    end

    bit   sml_loop = 1'b1;
    logic sml_const = 1'b0;
    assign miso_sml = sml_loop ? mosi_sml : sml_const;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick1();
        @(posedge clk);
        #1;
    endtask

    // Runs one wide transfer from IDLE; tx_data is scrambled right after acceptance.
    task automatic run_big(input vec_t v);
        int cyc;
        int got;
        tx_cur     = v.tx;
        slave_word = v.slave;
        big_loop   = v.loop;
        tx_big     = v.tx;
        start_big  = 1'b1;
        tick1();
        start_big = 1'b0;
        tx_big    = ~v.tx;
        cyc = 1;
        got = -1;
        while (cyc <= 200 && got < 0) begin
            if (done_big) got = cyc;
            else begin
                tick1();
                cyc++;
            end
        end
        chk("done_cycle", got, 45);
        chk("rx_data", rx_big, v.exp_rx);
        chk("sclk_rises", rises, 10);
        chk("mosi_stable", mosi_bad, 0);
        tick1();
        chk("done_single", done_big, 0);
        chk("cs_n_gap", cs_n_big, 1);
        chk("rx_hold", rx_big, v.exp_rx);
    endtask

    task automatic run_sml(input logic [1:0] tx, input bit loop, input logic c, input logic [1:0] exp_rx);
        logic [6:0] sclk_exp;
        sclk_exp  = 7'b0010100;
        sml_loop  = loop;
        sml_const = c;
        tx_sml    = tx;
        start_sml = 1'b1;
        tick1();
        start_sml = 1'b0;
        tx_sml    = ~tx;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            chk("sml_sclk", sclk_sml, sclk_exp[cyc-1]);
            chk("sml_done", done_sml, (cyc == 7) ? 1'b1 : 1'b0);
            if (cyc < 7) tick1();
        end
        chk("sml_rx", rx_sml, exp_rx);
        tick1();
        chk("sml_idle", busy_sml, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[6];
        int   ndone, d1, d2;
        vecs[0] = '{tx: 10'h2B5, slave: 10'h000, loop: 1'b1, exp_rx: 10'h2B5};
        vecs[1] = '{tx: 10'h000, slave: 10'h3C1, loop: 1'b0, exp_rx: 10'h3C1};
        vecs[2] = '{tx: 10'h3FF, slave: 10'h000, loop: 1'b0, exp_rx: 10'h000};
        vecs[3] = '{tx: 10'h155, slave: 10'h2AA, loop: 1'b0, exp_rx: 10'h2AA};
        vecs[4] = '{tx: 10'h200, slave: 10'h000, loop: 1'b1, exp_rx: 10'h200};
        vecs[5] = '{tx: 10'h001, slave: 10'h201, loop: 1'b0, exp_rx: 10'h201};

        rst_big = 1'b1; start_big = 1'b0; tx_big = '0;
        rst_sml = 1'b1; start_sml = 1'b0; tx_sml = '0;
        repeat (3) tick1();
        chk("rst_cs_n", cs_n_big, 1);
        chk("rst_sclk", sclk_big, 0);
        chk("rst_mosi", mosi_big, 0);
        chk("rst_busy", busy_big, 0);
        chk("rst_done", done_big, 0);
        chk("rst_rx", rx_big, 0);
        chk("rst_sml_rx", rx_sml, 0);

        start_big = 1'b1;
        tx_big    = 10'h3FF;
        tick1();
        chk("rst_over_start", busy_big, 0);
        start_big = 1'b0;
        rst_big   = 1'b0;
        rst_sml   = 1'b0;
        tick1();

        for (int i = 0; i < 6; i++) run_big(vecs[i]);

        // Starts at cycles 5 and 45 must be dropped.
        tx_cur = 10'h0F0; big_loop = 1'b1; tx_big = 10'h0F0;
        start_big = 1'b1;
        tick1();
        start_big = 1'b0;
        ndone = 0; d1 = -1;
        for (int cyc = 1; cyc <= 50; cyc++) begin
            if (done_big) begin
                ndone++;
                if (d1 < 0) d1 = cyc;
            end
            if (cyc == 20) chk("rx_hold_busy", rx_big, 10'h201);
            if (cyc == 46) chk("ign_cs_n_gap", cs_n_big, 1);
            if (cyc == 47) chk("ign_no_queue", busy_big, 0);
            start_big = (cyc == 5 || cyc == 45);
            tick1();
        end
        start_big = 1'b0;
        chk("ign_done_count", ndone, 1);
        chk("ign_done_cycle", d1, 45);
        chk("ign_rx", rx_big, 10'h0F0);

        // Start held high: back-to-back transfers.
        tx_cur = 10'h155; tx_big = 10'h155; big_loop = 1'b1;
        start_big = 1'b1;
        tick1();
        ndone = 0; d1 = -1; d2 = -1;
        for (int cyc = 1; cyc <= 95; cyc++) begin
            if (done_big) begin
                ndone++;
                if (d1 < 0) d1 = cyc;
                else if (d2 < 0) d2 = cyc;
            end
            if (cyc == 46) chk("b2b_cs_n_gap", cs_n_big, 1);
            if (cyc == 93) chk("b2b_idle", busy_big, 0);
            if (cyc == 50) start_big = 1'b0;
            tick1();
        end
        chk("b2b_done_count", ndone, 2);
        chk("b2b_first", d1, 45);
        chk("b2b_second", d2, 91);
        chk("b2b_rx", rx_big, 10'h155);

        // Reset at cycle 20 aborts without done.
        tx_cur = 10'h2B5; tx_big = 10'h2B5; big_loop = 1'b1;
        start_big = 1'b1;
        tick1();
        start_big = 1'b0;
        for (int cyc = 1; cyc < 20; cyc++) tick1();
        rst_big = 1'b1;
        tick1();
        rst_big = 1'b0;
        chk("abort_cs_n", cs_n_big, 1);
        chk("abort_sclk", sclk_big, 0);
        chk("abort_rx", rx_big, 0);
        chk("abort_done", done_big, 0);
        chk("abort_busy", busy_big, 0);
        ndone = 0;
        for (int cyc = 0; cyc < 50; cyc++) begin
            if (done_big) ndone++;
            tick1();
        end
        chk("abort_no_done", ndone, 0);
        run_big(vecs[0]);

        run_sml(2'b10, 1'b1, 1'b0, 2'b10);
        run_sml(2'b01, 1'b1, 1'b0, 2'b01);
        run_sml(2'b00, 1'b0, 1'b1, 2'b11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/spi_master_ctrl.md
SPI_MASTER_CTRL -- requirements
Module: spi_master_ctrl

Interface
REQ-001 Parameter WIDTH, default 10: bits per transfer; legal range 2..16.
REQ-002 Parameter CLK_DIV, default 2: clk cycles per SCLK half-period; legal range 1..255.
REQ-003 clk  input  1  sole clock; all logic on its rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 start  input  1  transfer request; sampled only in IDLE.
REQ-006 tx_data  input  WIDTH  word to transmit; captured on the cycle start is accepted.
REQ-007 miso  input  1  serial data from slave.
REQ-008 sclk  output  1  SPI clock, mode 0 (idle low).
REQ-009 mosi  output  1  serial data to slave, MSB first.
REQ-010 cs_n  output  1  slave select, active-low.
REQ-011 rx_data  output  WIDTH  last received word, MSB = first bit sampled.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  single-cycle pulse at transfer completion.

Function
REQ-014 States SHALL be IDLE, SETUP, SHIFT, HOLD, DONE.
REQ-015 IDLE: cs_n=1, sclk=0, busy=0; start=1 loads tx_data into the tx shift register, clears bit counter, next state SETUP.
REQ-016 SETUP: cs_n=0, sclk=0, mosi=tx_data[WIDTH-1]; lasts exactly CLK_DIV cycles, then SHIFT.
REQ-017 SHIFT: sclk toggles every CLK_DIV cycles, first edge rising; lasts exactly 2*WIDTH*CLK_DIV cycles.
REQ-018 On each sclk rising edge, miso SHALL be shifted into the LSB of the rx shift register (shift left) and the bit counter incremented.
REQ-019 On each sclk falling edge except the last, the tx shift register SHALL shift left so mosi presents the next bit.
REQ-020 After the WIDTH-th falling edge, next state HOLD with sclk=0.
REQ-021 HOLD: cs_n=0, sclk=0; lasts exactly CLK_DIV cycles, then DONE.
REQ-022 DONE: one cycle; done=1, cs_n=1, rx_data updated from rx shift register in that cycle; next state IDLE.
REQ-023 Latency: start accepted in cycle 0 -> done=1 in cycle 1+(2*WIDTH+2)*CLK_DIV.
REQ-024 rx_data SHALL hold its value between transfers and change only in DONE.
REQ-025 start while busy=1 (including the DONE cycle) SHALL be ignored, not queued.
REQ-026 tx_data changes after acceptance SHALL not affect the transfer in progress.
REQ-027 Back-to-back: start held high through DONE begins the next transfer from IDLE, giving at least one cycle of cs_n=1 between transfers.
REQ-028 Bit counter width SHALL be $clog2(WIDTH+1); half-period counter width $clog2(CLK_DIV+1).

Reset
REQ-029 rst=1 at a clock edge SHALL force IDLE, cs_n=1, sclk=0, mosi=0, busy=0, done=0, rx_data=0, counters=0, in any state.
REQ-030 Reset mid-transfer SHALL abort without a done pulse; partial rx bits are discarded.
REQ-031 rst has priority over start on the same edge.

Structure
REQ-032 Package spi_pkg SHALL hold the state enum type and default WIDTH/CLK_DIV constants.
REQ-033 One sub-module spi_clk_div SHALL generate the half-period tick (enable, count clear, tick output); FSM and shift registers stay in spi_master_ctrl.

Verification
REQ-034 WIDTH=10, CLK_DIV=2, tx_data=10'h2B5, slave loopback miso=mosi -> done at cycle 45, rx_data=10'h2B5, exactly 10 sclk rising edges.
REQ-035 Slave model drives 10'h3C1 MSB-first, changing on falling edges -> rx_data=10'h3C1; mosi stable at each rising edge.
REQ-036 start pulsed again at cycles 5 and 45 of a transfer -> ignored; single done pulse; cs_n high at least one cycle before the next transfer.
REQ-037 rst asserted at cycle 20 of a transfer -> next cycle cs_n=1, sclk=0, rx_data=0, no done; new start then completes normally.
REQ-038 CLK_DIV=1, WIDTH=2, tx_data=2'b10 -> done at cycle 7; sclk period 2 clk cycles.
REQ-039 start held high continuously -> consecutive transfers, each done one cycle, cs_n=1 for at least one cycle between transfers.
